dca_matrix_register_stream: RTL and testbench



---
 rtl/dca_matrix_stream_pkg.sv | 30 +++
 rtl/dca_matrix_stream_ctrl.sv | 67 ++++++
 rtl/dca_matrix_register_stream.sv | 105 ++++++++++
 tb/tb_dca_matrix_register_stream.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_stream_pkg.sv
// dca_matrix_stream_pkg: shared widths, storage-update op encoding and row-index helper
package dca_matrix_stream_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INIT,
        OP_WRITE_ALL,
        OP_TRANSPOSE,
        OP_SHIFT_LOAD,
        OP_ROTATE
    } op_e;

    function automatic int bw_tensor_row(input int num_col, input int bw_scalar);
        return num_col * bw_scalar;
    endfunction

    function automatic int bw_tensor_matrix(input int num_row, input int num_col, input int bw_scalar);
        return num_row * num_col * bw_scalar;
    endfunction

    function automatic int bw_count(input int num_row);
        return $clog2(num_row + 1);
    endfunction

    // Valid rows sit at the bottom, so the oldest one is num_row-count (num_row when empty).
    function automatic int oldest_row(input int num_row, input int count);
        return num_row - count;
    endfunction

endpackage

// File: rtl/dca_matrix_stream_ctrl.sv
// dca_matrix_stream_ctrl: occupancy counter, handshake gating and storage-update op decode
module dca_matrix_stream_ctrl
    import dca_matrix_stream_pkg::*;
#(
    parameter int MATRIX_NUM_ROW = 8,
    localparam int BW_COUNT = bw_count(MATRIX_NUM_ROW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                all_wenable,
    input  logic                transpose,
    input  logic                load_valid,
    input  logic                drain_ready,
    input  logic                recirc,
    output logic                load_ready,
    output logic                drain_valid,
    output logic                full,
    output logic                empty,
    output logic [BW_COUNT-1:0] count,
    output op_e                 op
);

    localparam logic [BW_COUNT-1:0] COUNT_FULL = BW_COUNT'(MATRIX_NUM_ROW);

    logic transpose_cmd;
    logic blocked;
    logic load_fire;
    logic drain_fire;
    logic rotate;

`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
    assign transpose_cmd = transpose;
`else
    logic unused_transpose;
    assign unused_transpose = transpose;
    assign transpose_cmd    = 1'b0;
`endif

    assign full        = count == COUNT_FULL;
    assign empty       = count == '0;
    assign blocked     = init || all_wenable || transpose_cmd;
    assign drain_valid = !empty && !blocked;
    assign drain_fire  = drain_valid && drain_ready;
    assign load_ready  = (!full || drain_fire) && !blocked;
    assign load_fire   = load_valid && load_ready;
    // A concurrent load takes the freed slot, so recirculation only happens on a lone drain.
    assign rotate      = drain_fire && recirc && full && !load_fire;

    always_comb
        op = init                  ? OP_INIT       :
             all_wenable           ? OP_WRITE_ALL  :
             transpose_cmd && full ? OP_TRANSPOSE  :
             load_fire             ? OP_SHIFT_LOAD :
             rotate                ? OP_ROTATE     : OP_HOLD;

    always_ff @(posedge clk)
        if (rst || init)
            count <= '0;
        else if (all_wenable)
            count <= COUNT_FULL;
        else if (load_fire && !drain_fire)
            count <= count + BW_COUNT'(1);
        else if (drain_fire && !load_fire && !rotate)
            count <= count - BW_COUNT'(1);

endmodule

// File: rtl/dca_matrix_register_stream.sv
// dca_matrix_register_stream: row-streaming matrix register with load/drain handshakes and recirculating drain
// Optional in-place transpose is built only when DCA_MATRIX_STREAM_TRANSPOSE_EN is defined.
module dca_matrix_register_stream
    import dca_matrix_stream_pkg::*;
#(
    parameter int                          MATRIX_NUM_ROW   = 8,
    parameter int                          MATRIX_NUM_COL   = 8,
    parameter int                          BW_TENSOR_SCALAR = 32,
    parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE      = '0,
    parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE       = RESET_VALUE,
    localparam int BW_TENSOR_ROW    = bw_tensor_row(MATRIX_NUM_COL, BW_TENSOR_SCALAR),
    localparam int BW_TENSOR_MATRIX = bw_tensor_matrix(MATRIX_NUM_ROW, MATRIX_NUM_COL, BW_TENSOR_SCALAR),
    localparam int BW_COUNT         = bw_count(MATRIX_NUM_ROW)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        all_wenable,
    input  logic [BW_TENSOR_MATRIX-1:0] all_wdata_list2d,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [BW_TENSOR_ROW-1:0]    load_data,
    output logic                        drain_valid,
    input  logic                        drain_ready,
    output logic [BW_TENSOR_ROW-1:0]    drain_data,
    input  logic                        recirc,
    input  logic                        transpose,
    output logic [BW_TENSOR_MATRIX-1:0] all_rdata_list2d,
    output logic [BW_COUNT-1:0]         count,
    output logic                        full,
    output logic                        empty
);

`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
    if (MATRIX_NUM_ROW != MATRIX_NUM_COL) begin : g_square_check
        $error("dca_matrix_register_stream: transpose requires MATRIX_NUM_ROW == MATRIX_NUM_COL");
    end
`endif

    logic [MATRIX_NUM_ROW-1:0][MATRIX_NUM_COL-1:0][BW_TENSOR_SCALAR-1:0] mem;
    logic [MATRIX_NUM_ROW-1:0][MATRIX_NUM_COL-1:0][BW_TENSOR_SCALAR-1:0] mem_nxt;
    op_e op;

    dca_matrix_stream_ctrl #(
        .MATRIX_NUM_ROW(MATRIX_NUM_ROW)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .all_wenable(all_wenable),
        .transpose  (transpose),
        .load_valid (load_valid),
        .drain_ready(drain_ready),
        .recirc     (recirc),
        .load_ready (load_ready),
        .drain_valid(drain_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .op         (op)
    );

    always_comb begin
        mem_nxt = mem;
        case (op)
            OP_INIT:
                for (int r = 0; r < MATRIX_NUM_ROW; r++)
                    for (int c = 0; c < MATRIX_NUM_COL; c++)
                        mem_nxt[r][c] = INIT_VALUE;
            OP_WRITE_ALL:
                mem_nxt = all_wdata_list2d;
`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
            OP_TRANSPOSE:
                for (int r = 0; r < MATRIX_NUM_ROW; r++)
                    for (int c = 0; c < MATRIX_NUM_COL; c++)
                        mem_nxt[r][c] = mem[c][r];
`endif
            OP_SHIFT_LOAD, OP_ROTATE: begin
                for (int r = 0; r < MATRIX_NUM_ROW - 1; r++)
                    mem_nxt[r] = mem[r+1];
                mem_nxt[MATRIX_NUM_ROW-1] = op == OP_ROTATE ? mem[0] : load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk)
        if (rst)
            for (int r = 0; r < MATRIX_NUM_ROW; r++)
                for (int c = 0; c < MATRIX_NUM_COL; c++)
                    mem[r][c] <= RESET_VALUE;
        else
            mem <= mem_nxt;

    // Oldest-row select straight off the registers; reads zero when empty.
    always_comb begin
        drain_data = '0;
        for (int r = 0; r < MATRIX_NUM_ROW; r++)
            if (r == oldest_row(MATRIX_NUM_ROW, int'(count)))
                drain_data = mem[r];
    end

    assign all_rdata_list2d = mem;

endmodule

// File: tb/tb_dca_matrix_register_stream.sv
// tb_dca_matrix_register_stream: directed plus randomized checks against a row-array reference model
module tb_dca_matrix_register_stream;

    localparam int N = 8;
    localparam int C = 8;
    localparam int BW = 32;
    localparam int BWC = 4;
    localparam logic [BW-1:0] INIT_V = 32'h5A5A_0001;

    typedef logic [C*BW-1:0] row_t;
    typedef logic [N*C*BW-1:0] mat_t;

    logic clk, rst, init, all_wenable, load_valid, load_ready, drain_valid, drain_ready;
    logic recirc, transpose, full, empty;
    mat_t all_wdata_list2d, all_rdata_list2d;
    row_t load_data, drain_data;
    logic [BWC-1:0] count;

    int vectors = 0;
    int miscompares = 0;
    row_t mrows[N];
    int mcnt;

    dca_matrix_register_stream #(
        .MATRIX_NUM_ROW(N),
        .MATRIX_NUM_COL(C),
        .BW_TENSOR_SCALAR(BW),
        .RESET_VALUE('0),
        .INIT_VALUE(INIT_V)
    ) dut (
        .clk(clk), .rst(rst), .init(init), .all_wenable(all_wenable),
        .all_wdata_list2d(all_wdata_list2d), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_data(drain_data), .recirc(recirc), .transpose(transpose),
        .all_rdata_list2d(all_rdata_list2d), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic row_t rnd_row();
        row_t x;
        for (int i = 0; i < C; i++) x[i*BW +: BW] = $urandom;
        return x;
    endfunction

    function automatic bit tr_on();
`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
        return transpose;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_dv();
        return mcnt > 0 && !init && !all_wenable && !tr_on();
    endfunction

    function automatic bit m_lr();
        return (mcnt < N || (m_dv() && drain_ready)) && !init && !all_wenable && !tr_on();
    endfunction

    task automatic idle();
        rst = 0; init = 0; all_wenable = 0; all_wdata_list2d = '0; load_valid = 0;
        load_data = '0; drain_ready = 0; recirc = 0; transpose = 0;
    endtask

    // Advance one clock and apply the same command to the reference model.
    task automatic tick();
        bit lf, df;
        row_t tmp[N];
        df = m_dv() && drain_ready;
        lf = load_valid && m_lr();
        @(posedge clk);
        if (rst) begin
            foreach (mrows[r]) mrows[r] = '0;
            mcnt = 0;
        end else if (init) begin
            foreach (mrows[r]) mrows[r] = {C{INIT_V}};
            mcnt = 0;
        end else if (all_wenable) begin
            foreach (mrows[r]) mrows[r] = all_wdata_list2d[r*C*BW +: C*BW];
            mcnt = N;
        end else if (tr_on() && mcnt == N) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < C; c++) tmp[r][c*BW +: BW] = mrows[c][r*BW +: BW];
            mrows = tmp;
        end else if (lf) begin
            for (int r = 0; r < N - 1; r++) mrows[r] = mrows[r+1];
            mrows[N-1] = load_data;
            if (!df) mcnt++;
        end else if (df) begin
            if (recirc && mcnt == N) begin
                tmp[N-1] = mrows[0];
                for (int r = 0; r < N - 1; r++) tmp[r] = mrows[r+1];
                mrows = tmp;
            end else mcnt--;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0; #1;
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset count got %0d exp 0", count); end
        vectors++; if ({empty, full} !== 2'b10) begin miscompares++; $display("FAIL reset flags got e%b f%b exp e1 f0", empty, full); end
        vectors++; if ({drain_valid, load_ready} !== 2'b01) begin miscompares++; $display("FAIL reset handshake got dv%b lr%b exp dv0 lr1", drain_valid, load_ready); end
        vectors++; if (all_rdata_list2d !== '0) begin miscompares++; $display("FAIL reset storage got %h exp 0", all_rdata_list2d[255:0]); end
    endtask

    task automatic test_fill();
        idle();
        for (int k = 1; k <= N; k++) begin
            load_valid = 1; load_data = row_t'(k); #1;
            vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL fill ready k=%0d got %b exp 1", k, load_ready); end
            tick();
            vectors++; if (count !== BWC'(k)) begin miscompares++; $display("FAIL fill count got %0d exp %0d", count, k); end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill full got %b exp 1", full); end
        vectors++; if (all_rdata_list2d[255:0] !== row_t'(1)) begin miscompares++; $display("FAIL fill row0 got %h exp 1", all_rdata_list2d[255:0]); end
        vectors++; if (all_rdata_list2d[2047:1792] !== row_t'(8)) begin miscompares++; $display("FAIL fill row7 got %h exp 8", all_rdata_list2d[2047:1792]); end
        load_data = row_t'(9); #1;
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL ninth load_ready got %b exp 0", load_ready); end
        tick();
        vectors++; if (count !== BWC'(8) || all_rdata_list2d[2047:1792] !== row_t'(8)) begin miscompares++; $display("FAIL ninth ignored count %0d row7 %h exp 8/8", count, all_rdata_list2d[2047:1792]); end
        idle();
    endtask

    task automatic test_drain_three();
        row_t a, b, c;
        idle(); init = 1; tick(); init = 0;
        a = rnd_row(); b = rnd_row(); c = rnd_row();
        load_valid = 1;
        load_data = a; tick(); load_data = b; tick(); load_data = c; tick();
        load_valid = 0; drain_ready = 1; #1;
        vectors++; if (drain_valid !== 1'b1 || drain_data !== a) begin miscompares++; $display("FAIL drain3 first got dv%b %h exp %h", drain_valid, drain_data, a); end
        tick(); drain_ready = 0;
        vectors++; if (count !== BWC'(2)) begin miscompares++; $display("FAIL drain3 count got %0d exp 2", count); end
        vectors++; if (all_rdata_list2d[5*256 +: 256] !== a || all_rdata_list2d[7*256 +: 256] !== c) begin miscompares++; $display("FAIL drain3 storage row5 %h exp %h", all_rdata_list2d[5*256 +: 256], a); end
        vectors++; if (drain_data !== b) begin miscompares++; $display("FAIL drain3 next got %h exp %h", drain_data, b); end
    endtask

    task automatic test_back_to_back(output row_t saved[N]);
        row_t q[$];
        row_t exp_d;
        idle(); init = 1; tick(); init = 0;
        load_valid = 1;
        for (int i = 0; i < N; i++) begin load_data = rnd_row(); q.push_back(load_data); tick(); end
        drain_ready = 1;
        for (int i = 0; i < 16; i++) begin
            load_data = rnd_row(); #1;
            exp_d = q.pop_front(); q.push_back(load_data);
            vectors++; if ({load_ready, drain_valid} !== 2'b11) begin miscompares++; $display("FAIL b2b bubble cyc %0d lr%b dv%b", i, load_ready, drain_valid); end
            vectors++; if (drain_data !== exp_d) begin miscompares++; $display("FAIL b2b order cyc %0d got %h exp %h", i, drain_data, exp_d); end
            tick();
            vectors++; if (count !== BWC'(N)) begin miscompares++; $display("FAIL b2b count got %0d exp 8", count); end
        end
        foreach (saved[i]) saved[i] = q[i];
        idle();
    endtask

    task automatic test_recirc(input row_t saved[N]);
        idle(); drain_ready = 1; recirc = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            vectors++; if (drain_valid !== 1'b1 || drain_data !== saved[i%N]) begin miscompares++; $display("FAIL recirc cyc %0d got %h exp %h", i, drain_data, saved[i%N]); end
            tick();
            vectors++; if (count !== BWC'(N)) begin miscompares++; $display("FAIL recirc count got %0d exp 8", count); end
        end
        idle();
    endtask

    task automatic test_init();
        idle(); load_valid = 1; load_data = rnd_row(); drain_ready = 1; init = 1; #1;
        vectors++; if ({load_ready, drain_valid} !== 2'b00) begin miscompares++; $display("FAIL init gating got lr%b dv%b exp 00", load_ready, drain_valid); end
        tick(); idle();
        vectors++; if (count !== '0 || empty !== 1'b1) begin miscompares++; $display("FAIL init count got %0d e%b exp 0 e1", count, empty); end
        vectors++; if (all_rdata_list2d !== {N*C{INIT_V}}) begin miscompares++; $display("FAIL init storage row0 got %h", all_rdata_list2d[255:0]); end
    endtask

    task automatic test_transpose();
        logic [BW-1:0] e;
        idle(); all_wenable = 1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < C; c++) all_wdata_list2d[(r*C+c)*BW +: BW] = 32'(r*C+c);
        load_valid = 1; drain_ready = 1; #1;
        vectors++; if ({load_ready, drain_valid} !== 2'b00) begin miscompares++; $display("FAIL allwrite gating got lr%b dv%b exp 00", load_ready, drain_valid); end
        tick(); idle();
        vectors++; if (count !== BWC'(N)) begin miscompares++; $display("FAIL allwrite count got %0d exp 8", count); end
        transpose = 1; #1;
`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
        vectors++; if (drain_valid !== 1'b0) begin miscompares++; $display("FAIL transpose dv got %b exp 0", drain_valid); end
`else
        vectors++; if (drain_valid !== 1'b1) begin miscompares++; $display("FAIL transpose dv got %b exp 1", drain_valid); end
`endif
        tick(); transpose = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < C; c++) begin
`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
                e = 32'(c*C+r);
`else
                e = 32'(r*C+c);
`endif
                vectors++; if (all_rdata_list2d[(r*C+c)*BW +: BW] !== e) begin miscompares++; $display("FAIL transpose el(%0d,%0d) got %0d exp %0d", r, c, all_rdata_list2d[(r*C+c)*BW +: BW], e); end
            end
        init = 1; tick(); init = 0;
        load_valid = 1; load_data = rnd_row(); tick(); load_data = rnd_row(); tick();
        transpose = 1; load_data = rnd_row(); #1;
`ifdef DCA_MATRIX_STREAM_TRANSPOSE_EN
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL transpose notfull lr got %b exp 0", load_ready); end
`else
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL transpose notfull lr got %b exp 1", load_ready); end
`endif
        tick(); idle();
        vectors++; if (count !== BWC'(mcnt)) begin miscompares++; $display("FAIL transpose notfull count got %0d exp %0d", count, mcnt); end
        for (int r = 0; r < N; r++) begin
            vectors++; if (all_rdata_list2d[r*256 +: 256] !== mrows[r]) begin miscompares++; $display("FAIL transpose notfull row%0d got %h exp %h", r, all_rdata_list2d[r*256 +: 256], mrows[r]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            idle();
            rst = $urandom_range(0, 79) == 0;
            init = $urandom_range(0, 39) == 0;
            all_wenable = $urandom_range(0, 29) == 0;
            for (int r = 0; r < N; r++) all_wdata_list2d[r*256 +: 256] = rnd_row();
            transpose = $urandom_range(0, 9) == 0;
            load_valid = $urandom_range(0, 3) != 0;
            load_data = rnd_row();
            drain_ready = $urandom_range(0, 2) != 0;
            recirc = $urandom_range(0, 2) == 0;
            #1;
            vectors++; if ({load_ready, drain_valid} !== {m_lr(), m_dv()}) begin miscompares++; $display("FAIL random hs cyc %0d got lr%b dv%b exp lr%b dv%b", i, load_ready, drain_valid, m_lr(), m_dv()); end
            if (m_dv()) begin
                vectors++; if (drain_data !== mrows[N-mcnt]) begin miscompares++; $display("FAIL random drain cyc %0d got %h exp %h", i, drain_data, mrows[N-mcnt]); end
            end
            tick();
            vectors++; if ({count, full, empty} !== {BWC'(mcnt), mcnt == N, mcnt == 0}) begin miscompares++; $display("FAIL random count cyc %0d got %0d f%b e%b exp %0d", i, count, full, empty, mcnt); end
            for (int r = 0; r < N; r++) begin
                vectors++; if (all_rdata_list2d[r*256 +: 256] !== mrows[r]) begin miscompares++; $display("FAIL random row%0d cyc %0d got %h exp %h", r, i, all_rdata_list2d[r*256 +: 256], mrows[r]); end
            end
        end
        idle();
    endtask

    initial begin
        row_t saved[N];
        clk = 0; mcnt = 0;
        foreach (mrows[r]) mrows[r] = '0;
        idle();
        test_reset();
        test_fill();
        test_drain_three();
        test_back_to_back(saved);
        test_recirc(saved);
        test_init();
        test_transpose();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
